// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the execute-stage multiply/divide path: shift-add
// multiply or restoring divide over WIDTH iterations, stalling the pipeline meanwhile.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam logic [3:0] MUL_CODE = 4'b0111;
  localparam logic [3:0] DIV_CODE = 4'b0011;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // acc = accumulator (mul) / remainder (div); a_reg = multiplicand / dividend->quotient;
  // b_reg = multiplier / divisor magnitude
  logic [WIDTH-1:0] acc, a_reg, b_reg;
  logic             is_mul, sign_q;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b, rem_sh, rem_sub;
  logic             rem_ge;

  assign accept = start && !flush && (alu_ctrl == MUL_CODE || alu_ctrl == DIV_CODE)
                  && (state == IDLE || state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign stall  = busy || accept;
  assign done   = (state == DONE);

  always_comb begin
    abs_a   = op_a[WIDTH-1] ? -op_a : op_a;
    abs_b   = op_b[WIDTH-1] ? -op_b : op_b;
    rem_sh  = {acc[WIDTH-2:0], a_reg[WIDTH-1]};
    rem_ge  = (rem_sh >= b_reg);
    rem_sub = rem_sh - b_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      is_mul   <= 1'b0;
      sign_q   <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      is_mul <= (alu_ctrl == MUL_CODE);
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      if (alu_ctrl == MUL_CODE) begin
        a_reg <= op_a;
        b_reg <= op_b;
        state <= CALC;
      end else begin
        sign_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        a_reg  <= abs_a;
        b_reg  <= abs_b;
        if (op_b == '0) begin
          state    <= DONE;
          result   <= '1;
          div_zero <= 1'b1;
        end else begin
          state <= CALC;
        end
      end
    end else begin
      case (state)
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
          if (is_mul) begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
          end else begin
            acc   <= rem_ge ? rem_sub : rem_sh;
            a_reg <= {a_reg[WIDTH-2:0], rem_ge};
          end
        end
        FIX: begin
          result   <= is_mul ? acc : (sign_q ? -a_reg : a_reg);
          div_zero <= 1'b0;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the iterative multiply/divide path of the execute stage.
- Accepts the 4-bit ALU control code produced by ALU control decode.
- For multiply (4'b0111) or divide (4'b0011), it runs a shift-add multiplier or a restoring divider for WIDTH iterations.
- Stalls the pipeline while running, then presents the result with a one-cycle done pulse.
- All other ALU codes bypass this block.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, 6, iteration counter width (≥ clog2(WIDTH)+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled at clk edge.
- alu_ctrl  input  4  ALU control code; 4'b0111 = mul, 4'b0011 = div.
- op_a  input  WIDTH  multiplicand / dividend (two's complement).
- op_b  input  WIDTH  multiplier / divisor (two's complement).
- flush  input  1  pipeline kill; aborts the operation in flight.
- stall  output  1  hold upstream pipeline stages.
- busy  output  1  state is CALC or FIX.
- done  output  1  one-cycle result-valid pulse.
- result  output  WIDTH  mul: low WIDTH bits of product; div: signed quotient.
- div_zero  output  1  with done: last divide had op_b==0.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset values: state=IDLE; stall=0, busy=0, done=0, result=0, div_zero=0; counter and working regs 0.
- Accept condition: start=1 and alu_ctrl ∈ {0111, 0011} and state ∈ {IDLE, DONE} and flush=0.
  - Unsupported code: start ignored, state unchanged.
  - start while CALC/FIX: ignored.
- On accept (edge E0):
  - Latch the op type.
  - mul: acc=0, multiplicand=op_a, multiplier=op_b (raw bits; low WIDTH product bits are sign-independent).
  - div: latch sign_q = op_a[MSB] ^ op_b[MSB]; dividend=|op_a|, divisor=|op_b| (unsigned magnitudes; |−2^(WIDTH−1)| = 2^(WIDTH−1)); remainder=0.
  - Counter = WIDTH; next state CALC.
  - div with op_b==0: next state DONE directly; result = all ones; div_zero=1.
- CALC, one iteration per cycle, counter decrements each cycle; leave for FIX when the counter reaches 0 (exactly WIDTH cycles).
  - mul: if multiplier[0], acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1.
  - div (restoring): {rem,dividend} <<= 1; if rem ≥ divisor then rem −= divisor and set the quotient LSB.
- FIX (1 cycle):
  - div: quotient negated if sign_q.
  - mul: pass-through.
  - Write result; div_zero=0; next DONE.
- DONE (1 cycle): done=1; next IDLE unless a new accept occurs (back-to-back allowed).
- result and div_zero hold until overwritten at the next FIX or divide-by-zero accept.
- Latency, start sampled at the end of cycle 0:
  - CALC in cycles 1..WIDTH, FIX in cycle WIDTH+1, done in cycle WIDTH+2 (cycle 34 for WIDTH=32).
  - Divide-by-zero: done in cycle 1.
- stall (combinational) = busy | (accept condition true this cycle); low in DONE so the pipeline captures result.
- Signed overflow: −2^(WIDTH−1) / −1 yields −2^(WIDTH−1) (0x80000000); no exception.
- flush: at the next edge, state=IDLE and counter=0; a done pulse due that cycle is suppressed; result unchanged. flush has priority over start.
- reset mid-operation: immediate return to reset values at the edge.
- Remainder is computed internally but not output.

Test Plan:
- Reset for 2 cycles, then mul 7×6 → stall high in cycles 0..33; done=1 only in cycle 34; result=42; busy low afterward.
- div 100/7 → result=14 in the done cycle (cycle 34); div −100/7 → result=−14 (0xFFFFFFF2); div 100/−7 → 0xFFFFFFF2.
- div 5/0 → done in cycle 1, result=0xFFFFFFFF, div_zero=1, stall low in cycle 1; then div 0x80000000/0xFFFFFFFF → result=0x80000000, div_zero=0.
- mul 0xFFFFFFFF×0xFFFFFFFF → result=0x00000001; mul 0x80000000×2 → 0.
- start with alu_ctrl=0010 → no stall, busy=0, no done; start asserted during CALC → ignored, original op completes with the correct result.
- Start div, assert flush in cycle 10 → state IDLE at cycle 11, no done pulse, result keeps its prior value.
- Separately, assert reset in cycle 20 of a mul → all outputs 0 next cycle.
- Back-to-back: new mul accepted in the DONE cycle of the previous op → its done arrives WIDTH+2 cycles later with the correct result.
